fc_layer_sequencer: RTL and testbench

Sequences one fully-connected MNIST layer through the four-lane MAC accumulator. It streams 32-bit packed feature and weight words from synchronous-read memories and drains the accumulator pipeline. It then adds the per-neuron bias, shifts and saturates the sum to 8 bits, and hands each neuron result downstream over a valid/ready port. It sits between the feature, weight and bias memories and the MAC accumulator, under the top-level inference FSM (start/done).

---
 rtl/fc_layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer through the four-lane MAC: stream operands, drain the
// pipeline, add bias, shift/saturate to 8 bits and emit each neuron over valid/ready.
module fc_layer_sequencer #(
   parameter int unsigned IN_WORDS     = 196,
   parameter int unsigned OUT_NEURONS  = 10,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned SHIFT        = 8,
   parameter int unsigned FADDR_W      = 8,
   parameter int unsigned WADDR_W      = 11,
   parameter int unsigned NADDR_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [FADDR_W-1:0] feat_addr,
   input  logic [31:0]        feat_data,
   output logic [WADDR_W-1:0] wgt_addr,
   input  logic [31:0]        wgt_data,
   output logic [NADDR_W-1:0] bias_addr,
   input  logic [8:0]         bias_data,
   output logic               mac_en,
   output logic               mac_flush,
   output logic [31:0]        mac_feature,
   output logic [31:0]        mac_weight,
   input  logic [25:0]        mac_acc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NADDR_W-1:0] out_index,
   output logic [7:0]         out_data
);

   localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [FADDR_W-1:0] LAST_W = FADDR_W'(IN_WORDS - 1);
   localparam logic [NADDR_W-1:0] LAST_N = NADDR_W'(OUT_NEURONS - 1);
   localparam logic [DW-1:0]      LAST_D = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StFlush, StStream, StDrain, StPost, StEmit, StDone
   } state_e;

   state_e             state_q;
   logic [FADDR_W-1:0] w_q;
   logic [WADDR_W-1:0] wc_q;
   logic [NADDR_W-1:0] n_q;
   logic [DW-1:0]      d_q;
   logic [8:0]         bias_q;
   logic               abort_flush_q;
   logic [7:0]         out_data_q;
   logic [NADDR_W-1:0] out_index_q;

   logic [26:0] sum;
   logic [26:0] shifted;
   logic [7:0]  sat;

   assign sum     = {1'b0, mac_acc} + {18'd0, bias_q};
   assign shifted = sum >> SHIFT;
   assign sat     = (shifted > 27'd255) ? 8'hFF : shifted[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         w_q           <= '0;
         wc_q          <= '0;
         n_q           <= '0;
         d_q           <= '0;
         bias_q        <= '0;
         abort_flush_q <= 1'b0;
         out_data_q    <= '0;
         out_index_q   <= '0;
      end else begin
         abort_flush_q <= 1'b0;
         if (state_q != StIdle && abort) begin
            state_q       <= StIdle;
            abort_flush_q <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q <= StFlush;
                     n_q     <= '0;
                     w_q     <= '0;
                     wc_q    <= '0;
                  end
               end
               StFlush: state_q <= StStream;
               StStream: begin
                  // bias_addr was presented during FLUSH, so its data lands here
                  if (w_q == '0) bias_q <= bias_data;
                  w_q  <= w_q + FADDR_W'(1);
                  wc_q <= wc_q + WADDR_W'(1);
                  if (w_q == LAST_W) begin
                     state_q <= StDrain;
                     d_q     <= '0;
                  end
               end
               StDrain: begin
                  d_q <= d_q + DW'(1);
                  if (d_q == LAST_D) state_q <= StPost;
               end
               StPost: begin
                  out_data_q  <= sat;
                  out_index_q <= n_q;
                  state_q     <= StEmit;
               end
               StEmit: begin
                  if (out_ready) begin
                     if (n_q == LAST_N) begin
                        state_q <= StDone;
                     end else begin
                        n_q     <= n_q + NADDR_W'(1);
                        w_q     <= '0;
                        state_q <= StFlush;
                     end
                  end
               end
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Addresses run one word ahead of the data consumed in STREAM (1-cycle read latency).
   assign feat_addr   = (state_q == StStream) ? w_q + FADDR_W'(1) : w_q;
   assign wgt_addr    = (state_q == StStream) ? wc_q + WADDR_W'(1) : wc_q;
   assign bias_addr   = n_q;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign mac_en      = (state_q == StStream) || (state_q == StDrain);
   assign mac_flush   = (state_q == StFlush) || abort_flush_q;
   assign mac_feature = (state_q == StStream) ? feat_data : 32'd0;
   assign mac_weight  = (state_q == StStream) ? wgt_data : 32'd0;
   assign out_valid   = (state_q == StEmit);
   assign out_data    = out_data_q;
   assign out_index   = out_index_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: memories, a 3-stage MAC, a cycle-position
// reference model checked every cycle, plus literal timing/result expectations.
module tb_fc_layer_sequencer;

   localparam int IN       = 2;
   localparam int N        = 2;
   localparam int D        = 3;
   localparam int SH       = 4;
   localparam int EMIT_POS = IN + D + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b1;
   logic        busy, done, mac_en, mac_flush, out_valid;
   logic [7:0]  feat_addr;
   logic [10:0] wgt_addr;
   logic [3:0]  bias_addr, out_index;
   logic [31:0] feat_data, wgt_data, mac_feature, mac_weight;
   logic [8:0]  bias_data;
   logic [25:0] mac_acc;
   logic [7:0]  out_data;

   logic [31:0] feat_mem [256];
   logic [31:0] wgt_mem  [2048];
   logic [8:0]  bias_mem [16];
   logic [7:0]  res [N];

   int checks = 0, failures = 0;
   int cycle = 0, c0 = 0;
   int hs_cnt = 0, done_cnt = 0, done_at = 0, en_cnt = 0;
   logic [7:0] last_data = 8'd0;
   bit chk_en = 1'b0;

   fc_layer_sequencer #(
      .IN_WORDS(IN), .OUT_NEURONS(N), .DRAIN_CYCLES(D), .SHIFT(SH),
      .FADDR_W(8), .WADDR_W(11), .NADDR_W(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .feat_addr(feat_addr), .feat_data(feat_data), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
      .bias_addr(bias_addr), .bias_data(bias_data), .mac_en(mac_en), .mac_flush(mac_flush),
      .mac_feature(mac_feature), .mac_weight(mac_weight), .mac_acc(mac_acc),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   always @(posedge clk) begin
      feat_data <= feat_mem[feat_addr];
      wgt_data  <= wgt_mem[wgt_addr];
      bias_data <= bias_mem[bias_addr];
   end

   function automatic logic [25:0] dot(input logic [31:0] f, input logic [31:0] g);
      logic [25:0] s;
      s = 26'd0;
      for (int l = 0; l < 4; l++) s += 26'(f[8*l +: 8]) * 26'(g[8*l +: 8]);
      return s;
   endfunction

   logic [25:0] p0 = 0, p1 = 0, p2 = 0, acc = 0;
   always @(posedge clk) begin
      if (rst || (mac_flush && !mac_en)) begin
         p0 <= 0; p1 <= 0; p2 <= 0; acc <= 0;
      end else if (mac_en) begin
         p0 <= dot(mac_feature, mac_weight);
         p1 <= p0;
         p2 <= p1;
         acc <= acc + p2;
      end
   end
   assign mac_acc = acc;

   // Reference: position within a neuron (0 flush, 1..IN stream, then drain, post, emit).
   bit m_act = 0, m_dph = 0, m_afl = 0, m_rst = 0;
   int m_n = 0, m_pos = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_act <= 0; m_dph <= 0; m_afl <= 0; m_rst <= 1; m_n <= 0; m_pos <= 0;
      end else begin
         m_rst <= 0;
         m_afl <= 0;
         if (!m_act && !m_dph) begin
            if (start) begin m_act <= 1; m_n <= 0; m_pos <= 0; end
         end else if (abort) begin
            m_act <= 0; m_dph <= 0; m_afl <= 1;
         end else if (m_dph) begin
            m_dph <= 0;
         end else if (m_pos == EMIT_POS) begin
            if (out_ready) begin
               if (m_n == N - 1) begin m_act <= 0; m_dph <= 1; end
               else begin m_n <= m_n + 1; m_pos <= 0; end
            end
         end else begin
            m_pos <= m_pos + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   initial begin : cmp
      bit st, dr, fl;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (m_rst) begin
               chk("rst_busy", 32'(busy), 0);      chk("rst_done", 32'(done), 0);
               chk("rst_mac_en", 32'(mac_en), 0);  chk("rst_flush", 32'(mac_flush), 0);
               chk("rst_valid", 32'(out_valid), 0); chk("rst_faddr", 32'(feat_addr), 0);
               chk("rst_waddr", 32'(wgt_addr), 0); chk("rst_baddr", 32'(bias_addr), 0);
               chk("rst_mfeat", mac_feature, 0);   chk("rst_mwgt", mac_weight, 0);
               chk("rst_odata", 32'(out_data), 0); chk("rst_oidx", 32'(out_index), 0);
            end else begin
               st = m_act && m_pos >= 1 && m_pos <= IN;
               dr = m_act && m_pos > IN && m_pos <= IN + D;
               fl = (m_act && m_pos == 0) || m_afl;
               chk("busy", 32'(busy), 32'(m_act || m_dph));
               chk("done", 32'(done), 32'(m_dph));
               chk("mac_en", 32'(mac_en), 32'(st || dr));
               if (!(st || dr)) chk("mac_flush", 32'(mac_flush), 32'(fl));
               chk("out_valid", 32'(out_valid), 32'(m_act && m_pos == EMIT_POS));
               chk("mac_feature", mac_feature, st ? feat_mem[m_pos-1] : 32'd0);
               chk("mac_weight", mac_weight, st ? wgt_mem[m_n*IN + m_pos-1] : 32'd0);
               if (m_act && m_pos <= IN) begin
                  chk("feat_addr", 32'(feat_addr), 32'(m_pos));
                  chk("wgt_addr", 32'(wgt_addr), 32'(m_n*IN + m_pos));
               end
               if (m_act) chk("bias_addr", 32'(bias_addr), 32'(m_n));
               if (m_act && m_pos == EMIT_POS) begin
                  chk("out_data", 32'(out_data), 32'(res[m_n]));
                  chk("out_index", 32'(out_index), 32'(m_n));
               end
            end
            if (out_valid === 1'b1 && out_ready) begin hs_cnt++; last_data = out_data; end
            if (done === 1'b1) begin done_cnt++; done_at = cycle - c0 + 1; end
            if (mac_en === 1'b1) en_cnt++;
         end
      end
   end

   function automatic logic [7:0] calc(input int n);
      longint s;
      logic [31:0] f, g;
      s = 0;
      for (int w = 0; w < IN; w++) begin
         f = feat_mem[w];
         g = wgt_mem[n*IN + w];
         for (int l = 0; l < 4; l++) s += longint'(f[8*l +: 8]) * longint'(g[8*l +: 8]);
      end
      s = (s + longint'(bias_mem[n])) >> SH;
      return (s > 255) ? 8'hFF : s[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_const(input logic [31:0] f, input logic [31:0] g, input logic [8:0] b);
      for (int i = 0; i < 256; i++) feat_mem[i] = f;
      for (int i = 0; i < 2048; i++) wgt_mem[i] = g;
      for (int i = 0; i < 16; i++) bias_mem[i] = b;
   endtask

   task automatic begin_layer();
      for (int k = 0; k < N; k++) res[k] = calc(k);
      hs_cnt = 0; done_cnt = 0; done_at = 0; en_cnt = 0;
      start = 1'b1;
      tick();
      c0 = cycle;
      start = 1'b0;
   endtask

   task automatic finish_layer(input string nm, input int exp_done_at);
      int i;
      for (i = 0; i < 200 && done_cnt == 0; i++) tick();
      if (done_cnt == 0) begin
         checks++; failures++;
         $display("FAIL %s_timeout: got no done expected done in cycle %0d", nm, exp_done_at);
      end
      repeat (3) tick();
      chk({nm, "_done_at"}, done_at, exp_done_at);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_results"}, hs_cnt, N);
      chk({nm, "_mac_en_cycles"}, en_cnt, N * (IN + D));
   endtask

   initial begin
      load_const(32'h01010101, 32'h02020202, 9'd16);
      tick();
      chk_en = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // nominal: 2*4*1*2 + 16 = 32, >> 4 = 2
      begin_layer();
      finish_layer("nominal", 17);
      chk("nominal_data", 32'(last_data), 32'd2);

      // start pulsed while busy is ignored
      begin_layer();
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      finish_layer("start_busy", 17);
      chk("start_busy_data", 32'(last_data), 32'd2);

      // distinct words so any address slip shows on the operand buses
      load_const(32'hDEADBEEF, 32'hDEADBEEF, 9'd0);
      feat_mem[0] = 32'h04030201; feat_mem[1] = 32'h08070605;
      wgt_mem[0] = 32'h01020304;  wgt_mem[1] = 32'h05060708;
      wgt_mem[2] = 32'h11223344;  wgt_mem[3] = 32'h0A0B0C0D;
      bias_mem[0] = 9'd100;       bias_mem[1] = 9'd300;
      begin_layer();
      finish_layer("pattern", 17);

      // saturation: 2*4*255*255 + 511 = 520711
      load_const(32'hFFFFFFFF, 32'hFFFFFFFF, 9'd511);
      begin_layer();
      finish_layer("saturate", 17);
      chk("saturate_data", 32'(last_data), 32'hFF);

      // backpressure: 5 stall cycles in the first EMIT
      load_const(32'h01010101, 32'h02020202, 9'd16);
      begin_layer();
      repeat (6) tick();
      out_ready = 1'b0;
      repeat (6) tick();
      out_ready = 1'b1;
      finish_layer("backpressure", 22);

      // abort in the first STREAM cycle of neuron 1
      begin_layer();
      repeat (9) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_flush", 32'(mac_flush), 1);
      chk("abort_busy", 32'(busy), 0);
      repeat (20) tick();
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_results", hs_cnt, 1);
      begin_layer();
      finish_layer("after_abort", 17);

      // reset while draining neuron 0
      begin_layer();
      repeat (3) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (20) tick();
      chk("rst_mid_done_cnt", done_cnt, 0);
      chk("rst_mid_results", hs_cnt, 0);

      // start and abort together in IDLE: start wins
      abort = 1'b1;
      begin_layer();
      abort = 1'b0;
      finish_layer("start_abort", 17);
      chk("start_abort_data", 32'(last_data), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
